// File: rtl/lip_synth_master_if.sv
// Front-panel and datapath-facing signals of the lip-synth mode controller.
// The controller uses the master view; whatever drives the buttons uses the slave view.
interface lip_synth_master_if;
    logic       center_but;
    logic       down_but;
    logic       left_but;
    logic       right_but;
    logic       done_recording;
    logic [1:0] state;
    logic [5:0] root;

    modport master (
        input  center_but, down_but, left_but, right_but, done_recording,
        output state, root
    );

    modport slave (
        output center_but, down_but, left_but, right_but, done_recording,
        input  state, root
    );
endinterface

// File: rtl/lip_synth_master.sv
// Mode controller for the lip-synth player piano: tracks jam/composer/player mode
// from button presses and owns the saturating root note adjusted in jam mode.
module lip_synth_master #(
    parameter int ROOT_MIN      = 1,
    parameter int ROOT_MAX      = 56,
    parameter int ROOT_RESET    = 28,
    parameter int REPEAT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    lip_synth_master_if.master bus
);

    typedef enum logic [1:0] {
        JAM_SESH    = 2'b00,
        COMPOSER    = 2'b01,
        SONG_PLAYER = 2'b10,
        ILLEGAL     = 2'b11
    } mode_e;

    localparam int              CNT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [5:0]      ROOT_LO  = 6'(ROOT_MIN);
    localparam logic [5:0]      ROOT_HI  = 6'(ROOT_MAX);
    localparam logic [5:0]      ROOT_RST = 6'(ROOT_RESET);

    mode_e            state_q, state_d;
    logic [5:0]       root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             center_q, down_q;
    logic             center_press, down_press;
    logic             one_dir_held;

    assign center_press = bus.center_but & ~center_q;
    assign down_press   = bus.down_but & ~down_q;
    assign one_dir_held = bus.left_but ^ bus.right_but;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= JAM_SESH;
            root_q   <= ROOT_RST;
            cnt_q    <= '0;
            center_q <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            center_q <= bus.center_but;
            down_q   <= bus.down_but;
        end
    end

    // NOTE: next-state defaults are assigned first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            JAM_SESH: begin
                if (center_press)    state_d = COMPOSER;
                else if (down_press) state_d = SONG_PLAYER;
            end
            COMPOSER: begin
                if (center_press || bus.done_recording) state_d = JAM_SESH;
            end
            SONG_PLAYER: begin
                if (down_press) state_d = JAM_SESH;
            end
            default: state_d = JAM_SESH;
        endcase
    end

    // Root stepping: bounds are checked before the add/subtract, so the 6-bit
    // value can never wrap.
    always_comb begin
        root_d = root_q;
        cnt_d  = '0;
        if (state_q == JAM_SESH && one_dir_held) begin
            if (cnt_q == '0) begin
                if (bus.right_but && root_q < ROOT_HI)     root_d = root_q + 6'd1;
                else if (bus.left_but && root_q > ROOT_LO) root_d = root_q - 6'd1;
            end
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign bus.state = state_q;
    assign bus.root  = root_q;

endmodule

// File: tb/tb_lip_synth_master.sv
// Directed bench for lip_synth_master: a behavioural model pushes the expected
// mode/root per cycle into a scoreboard that is popped after each clock edge.
module tb_lip_synth_master;

    logic clk = 1'b0;
    logic reset;
    lip_synth_master_if bus ();

    lip_synth_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] state;
        logic [5:0] root;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model of the controller
    logic [1:0] m_state;
    logic [5:0] m_root;
    logic       m_pc, m_pd;

    task automatic compare(input string tag, input logic [1:0] exp_state, input logic [5:0] exp_root);
        vectors++;
        assert (bus.state === exp_state && bus.root === exp_root)
        else begin
            miscompares++;
            $error("FAIL %s: observed state=%b root=%0d expected state=%b root=%0d",
                   tag, bus.state, bus.root, exp_state, exp_root);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            compare(e.tag, e.state, e.root);
        end
    endtask

    task automatic cycle(input logic c, input logic d, input logic l, input logic r,
                         input logic dr, input string tag);
        logic pc, pd;
        exp_t e;
        bus.center_but     = c;
        bus.down_but       = d;
        bus.left_but       = l;
        bus.right_but      = r;
        bus.done_recording = dr;
        pc = c && !m_pc;
        pd = d && !m_pd;
        if (m_state == 2'b00 && (l != r)) begin
            if (r) m_root = (m_root >= 6'd56) ? 6'd56 : m_root + 6'd1;
            else   m_root = (m_root <= 6'd1)  ? 6'd1  : m_root - 6'd1;
        end
        case (m_state)
            2'b00:   m_state = pc ? 2'b01 : (pd ? 2'b10 : 2'b00);
            2'b01:   m_state = (pc || dr) ? 2'b00 : 2'b01;
            2'b10:   m_state = pd ? 2'b00 : 2'b10;
            default: m_state = 2'b00;
        endcase
        m_pc = c;
        m_pd = d;
        e.tag = tag; e.state = m_state; e.root = m_root;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    task automatic hold(input logic c, input logic d, input logic l, input logic r,
                        input logic dr, input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(c, d, l, r, dr, tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic apply_reset(input logic l, input string tag);
        exp_t e;
        reset              = 1'b1;
        bus.center_but     = 1'b0;
        bus.down_but       = 1'b0;
        bus.left_but       = l;
        bus.right_but      = 1'b0;
        bus.done_recording = 1'b0;
        m_state = 2'b00; m_root = 6'd28; m_pc = 1'b0; m_pd = 1'b0;
        e.tag = tag; e.state = 2'b00; e.root = 6'd28;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.center_but = 1'b0; bus.down_but = 1'b0;
        bus.left_but = 1'b0; bus.right_but = 1'b0; bus.done_recording = 1'b0;
        @(negedge clk);

        // 1: reset
        apply_reset(1'b0, "reset");
        compare("reset_const", 2'b00, 6'd28);

        // 2: composer round trip
        cycle(1, 0, 0, 0, 0, "c_to_composer");
        compare("composer_const", 2'b01, 6'd28);
        idle("idle");
        cycle(1, 0, 0, 0, 0, "c_to_jam");
        idle("idle");
        cycle(0, 0, 0, 0, 1, "dr_in_jam");
        compare("dr_ignored_jam", 2'b00, 6'd28);
        cycle(1, 0, 0, 0, 0, "c_to_composer2");
        cycle(0, 0, 0, 0, 1, "dr_to_jam");
        compare("dr_exit_composer", 2'b00, 6'd28);

        // 3: song player
        cycle(0, 1, 0, 0, 0, "d_to_player");
        compare("player_const", 2'b10, 6'd28);
        idle("idle");
        cycle(1, 0, 0, 0, 0, "c_in_player");
        cycle(0, 0, 0, 0, 1, "dr_in_player");
        compare("player_holds", 2'b10, 6'd28);
        cycle(0, 1, 0, 0, 0, "d_to_jam");
        idle("idle");
        cycle(1, 0, 0, 0, 0, "c_to_composer3");
        idle("idle");
        cycle(0, 1, 0, 0, 0, "d_in_composer");
        compare("down_ignored_composer", 2'b01, 6'd28);
        idle("idle");
        cycle(1, 0, 0, 0, 0, "c_back_jam");
        idle("idle");
        cycle(1, 1, 0, 0, 0, "c_and_d_jam");
        compare("center_wins", 2'b01, 6'd28);
        idle("idle");
        cycle(1, 0, 0, 0, 0, "c_back_jam2");
        idle("idle");

        // 4: root saturation
        hold(0, 0, 1, 0, 0, 40, "left40");
        compare("root_floor", 2'b00, 6'd1);
        hold(0, 0, 0, 1, 0, 80, "right80");
        compare("root_ceiling", 2'b00, 6'd56);
        hold(0, 0, 1, 1, 0, 3, "both_held");
        compare("both_no_step", 2'b00, 6'd56);
        hold(0, 0, 1, 0, 0, 80, "left80");
        compare("root_floor2", 2'b00, 6'd1);
        hold(0, 0, 0, 1, 0, 40, "right40");
        compare("root_41", 2'b00, 6'd41);

        // 5: root frozen outside jam
        cycle(1, 0, 0, 0, 0, "c_to_composer4");
        hold(0, 0, 1, 0, 0, 4, "left_composer");
        compare("frozen_composer", 2'b01, 6'd41);
        cycle(1, 0, 0, 0, 0, "c_back_jam3");
        idle("idle");
        cycle(0, 1, 0, 0, 0, "d_to_player2");
        hold(0, 0, 1, 0, 0, 10, "left_player");
        compare("frozen_player", 2'b10, 6'd41);
        cycle(0, 1, 0, 0, 0, "d_back_jam");
        idle("idle");

        // 6: held center, then reset mid-hold
        hold(1, 0, 0, 0, 0, 5, "center_held5");
        compare("one_transition", 2'b01, 6'd41);
        idle("idle");
        cycle(1, 0, 0, 0, 0, "c_back_jam4");
        idle("idle");
        hold(0, 0, 1, 0, 0, 3, "left_before_reset");
        compare("pre_reset_root", 2'b00, 6'd38);
        apply_reset(1'b1, "reset_mid_hold");
        compare("reset_mid_hold_const", 2'b00, 6'd28);

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lip_synth_master.md
Name: lip_synth_master

Overview:
- Top-level mode controller for the lip-synth player piano.
- Tracks the operating mode (jam session, composer, song player) from front-panel buttons and the recorder's done flag.
- Owns the musical root note, which is adjusted with left/right buttons in jam-session mode only.
- Outputs drive the synth, recorder and player datapaths.

Parameters:
- ROOT_MIN, 1, lowest legal root value (saturation floor).
- ROOT_MAX, 56, highest legal root value (saturation ceiling).
- ROOT_RESET, 28, root value after reset.
- REPEAT_CYCLES, 1, clock cycles between root steps while left/right is held (1 = step every cycle).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- center_but  input  1  centre button, debounced level, clk-synchronous.
- down_but  input  1  down button, debounced level.
- left_but  input  1  left button, level; decrements root.
- right_but  input  1  right button, level; increments root.
- done_recording  input  1  composer recording-complete flag, level.
- state  output  2  current mode: 2'b00 JAM_SESH, 2'b01 COMPOSER, 2'b10 SONG_PLAYER.
- root  output  6  current root note, range ROOT_MIN..ROOT_MAX.

Behaviour:
Reset:
- reset=1 at a clock edge sets state=JAM_SESH, root=ROOT_RESET, button-history registers=0 and repeat counter=0.
- Reset takes priority over everything, including mid-press.

Edge detection:
- center_but and down_but are registered each cycle.
- A "press" is but=1 while its registered previous value is 0.
- Holding a button produces exactly one press.

State machine:
- state and root are registered outputs.
- The transition takes effect at the same clock edge that samples the press, so it is visible on the next cycle.
- JAM_SESH:
  - center press -> COMPOSER.
  - else down press -> SONG_PLAYER.
  - done_recording ignored.
- COMPOSER:
  - center press or done_recording=1 -> JAM_SESH.
  - down ignored.
- SONG_PLAYER:
  - down press -> JAM_SESH.
  - center and done_recording ignored.
- Encoding 2'b11 is illegal; it recovers to JAM_SESH on the next edge.
- Simultaneous center and down presses in JAM_SESH: center wins.

Root control (active only when state==JAM_SESH):
- Exactly one of left_but/right_but high: the repeat counter runs.
  - A step occurs on the first held cycle and every REPEAT_CYCLES cycles thereafter.
  - Right adds 1, left subtracts 1.
- Saturation:
  - Root never exceeds ROOT_MAX; a right step at ROOT_MAX holds it.
  - Root never drops below ROOT_MIN; a left step at ROOT_MIN holds it.
  - There is no wrap-around.
- Both held, or neither held: no step, and the counter clears.
- In COMPOSER or SONG_PLAYER: left/right are ignored, root holds, and the counter clears.
- The root value is retained across mode changes.

Arithmetic: 6-bit unsigned. Saturation is compared before the add/subtract, so no underflow below 0 and no overflow above 63 is ever produced.

Test Plan:
1. Reset held 1 cycle, all inputs 0 -> state=00, root=28.
2. Mode round trip:
   - center pulse 1 cycle -> state=01.
   - Second center pulse -> state=00.
   - done_recording pulse in JAM_SESH -> state stays 00.
   - center -> 01, then done_recording pulse -> 00.
3. Song player:
   - down pulse from 00 -> 10.
   - center pulse and done_recording pulse -> stay 10.
   - down -> 00.
   - center -> 01, then down pulse -> stays 01, then center -> 00.
4. Root saturation in JAM_SESH (REPEAT_CYCLES=1):
   - left held 40 cycles -> root reaches 1 and stays 1.
   - right held 80 cycles -> root 56, holds.
   - left held 80 cycles -> 1.
   - right held 40 cycles -> 41.
5. Root frozen outside JAM_SESH:
   - center -> COMPOSER, left held 4 cycles -> root unchanged (41); center -> JAM_SESH.
   - down -> SONG_PLAYER, left held 10 cycles -> root stays 41.
6. Held center for 5 cycles -> exactly one transition. Reset asserted mid-left-hold -> root=28, state=00 next cycle.
